// File: rtl/md_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one shared 33-bit adder, 32 shift iterations.
// Normal ops give md_done 35 cycles after the start edge; specials give it after 2 cycles.
module md_seq_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_start,
   input  logic [2:0]       md_func3,
   input  logic [XLEN-1:0]  md_op1,
   input  logic [XLEN-1:0]  md_op2,
   input  logic [4:0]       md_rd,
   input  logic             md_flush,
   output logic             md_stall,
   output logic             md_busy,
   output logic             md_done,
   output logic [XLEN-1:0]  md_result,
   output logic             md_wr_reg,
   output logic [4:0]       md_wr_regindex
);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          func3_q, func3_d;
   logic [4:0]          rd_q, rd_d;
   logic [XLEN-1:0]     op1_q, op1_d, op2_q, op2_d;
   logic [XLEN-1:0]     add_q, add_d, hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                s1_q, s1_d, s2_q, s2_d;

   logic                is_div, sgn1, sgn2, s1_now, s2_now, div0, ovf;
   logic [XLEN-1:0]     mag1, mag2, quot_fix, rem_fix, fix_res;
   logic [XLEN:0]       add_x, add_y, sum;
   logic [2*XLEN-1:0]   prod, prod_fix;

   always_comb begin
      is_div = func3_q[2];
      sgn1   = (func3_q == 3'd1) || (func3_q == 3'd2) || (func3_q == 3'd4) || (func3_q == 3'd6);
      sgn2   = (func3_q == 3'd1) || (func3_q == 3'd4) || (func3_q == 3'd6);
      s1_now = op1_q[XLEN-1] & sgn1;
      s2_now = op2_q[XLEN-1] & sgn2;
      mag1   = s1_now ? -op1_q : op1_q;
      mag2   = s2_now ? -op2_q : op2_q;
      div0   = is_div && (op2_q == '0);
      ovf    = is_div && !func3_q[0] && (op1_q == MIN_NEG) && (op2_q == '1);

      // Multiply adds the multiplicand into hi; divide trial-subtracts the divisor from {rem,next quot bit}.
      add_x  = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
      add_y  = is_div ? ~{1'b0, add_q} : {1'b0, add_q};
      sum    = add_x + add_y + {{XLEN{1'b0}}, is_div};

      prod     = {hi_q, lo_q};
      prod_fix = (s1_q ^ s2_q) ? -prod : prod;
      quot_fix = (s1_q ^ s2_q) ? -lo_q : lo_q;
      rem_fix  = s1_q ? -hi_q : hi_q;
      case (func3_q)
         3'd0:          fix_res = prod_fix[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:          fix_res = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:    fix_res = quot_fix;
         default:       fix_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func3_d  = func3_q;
      rd_d     = rd_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      add_d    = add_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (md_start && !md_flush) begin
               state_d = S_PREP;
               func3_d = md_func3;
               rd_d    = md_rd;
               op1_d   = md_op1;
               op2_d   = md_op2;
            end
         end
         S_PREP: begin
            if (md_flush) begin
               state_d = S_IDLE;
            end else if (div0) begin
               state_d  = S_DONE;
               result_d = func3_q[1] ? op1_q : '1;
            end else if (ovf) begin
               state_d  = S_DONE;
               result_d = func3_q[1] ? '0 : MIN_NEG;
            end else begin
               state_d = S_CALC;
               cnt_d   = '0;
               s1_d    = s1_now;
               s2_d    = s2_now;
               hi_d    = '0;
               add_d   = is_div ? mag2 : mag1;
               lo_d    = is_div ? mag1 : mag2;
            end
         end
         S_CALC: begin
            if (md_flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
               if (is_div) begin
                  lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
                  hi_d = sum[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : sum[XLEN-1:0];
               end else if (lo_q[0]) begin
                  hi_d = sum[XLEN:1];
                  lo_d = {sum[0], lo_q[XLEN-1:1]};
               end else begin
                  hi_d = {1'b0, hi_q[XLEN-1:1]};
                  lo_d = {hi_q[0], lo_q[XLEN-1:1]};
               end
            end
         end
         S_FIX: begin
            if (md_flush) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DONE;
               result_d = fix_res;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         func3_q  <= '0;
         rd_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         add_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func3_q  <= func3_d;
         rd_q     <= rd_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         add_q    <= add_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
      end
   end

   // Stall drops in DONE so the held instruction retires at the end of the done cycle.
   assign md_stall       = ((state_q == S_IDLE) && md_start && !md_flush) ||
                           (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
   assign md_busy        = (state_q != S_IDLE);
   assign md_done        = (state_q == S_DONE) && !md_flush;
   assign md_wr_reg      = md_done && (rd_q != 5'd0);
   assign md_wr_regindex = rd_q;
   assign md_result      = result_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Randomized bench for md_seq_ctrl against an arithmetic RV32M reference model.
module tb_md_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_start;
   logic [2:0]  md_func3;
   logic [31:0] md_op1, md_op2;
   logic [4:0]  md_rd;
   logic        md_flush;
   logic        md_stall, md_busy, md_done, md_wr_reg;
   logic [31:0] md_result;
   logic [4:0]  md_wr_regindex;

   int n_tests = 0;
   int n_fail  = 0;

   md_seq_ctrl dut (
      .clk(clk), .reset(reset), .md_start(md_start), .md_func3(md_func3),
      .md_op1(md_op1), .md_op2(md_op2), .md_rd(md_rd), .md_flush(md_flush),
      .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
      .md_wr_reg(md_wr_reg), .md_wr_regindex(md_wr_regindex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          qa, qb;
      sa = $signed(a);
      sb = $signed(b);
      ub = {32'b0, b};
      qa = $signed(a);
      qb = $signed(b);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return qa / qb;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return qa % qb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f >= 3'd4 && b == 0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Presents one op from the next negedge and tracks it until md_done; start stays high afterwards.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      int          done_cyc, stall_cnt, busy_cnt, lat;
      logic [31:0] res, exp;
      logic        wr;
      logic [4:0]  idx;
      exp       = ref_res(f, a, b);
      lat       = ref_lat(f, a, b);
      done_cyc  = -1;
      stall_cnt = 0;
      busy_cnt  = 0;
      res = 32'h0; wr = 1'b0; idx = 5'd0;
      @(negedge clk);
      md_start = 1'b1; md_flush = 1'b0;
      md_func3 = f; md_op1 = a; md_op2 = b; md_rd = rd;
      for (int c = 0; c < 60 && done_cyc < 0; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (md_stall) stall_cnt++;
         if (md_busy) busy_cnt++;
         if (md_done) begin
            done_cyc = c; res = md_result; wr = md_wr_reg; idx = md_wr_regindex;
         end
      end
      chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(lat));
      chk({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(lat));
      chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat));
      chk({tag, ".result"}, 64'(res), 64'(exp));
      chk({tag, ".wr_reg"}, 64'(wr), 64'(rd != 5'd0));
      chk({tag, ".regindex"}, 64'(idx), 64'(rd));
   endtask

   task automatic idle_hold(input string tag, input logic [31:0] exp);
      @(negedge clk);
      md_start = 1'b0; md_flush = 1'b0;
      #1;
      chk({tag, ".hold_result"}, 64'(md_result), 64'(exp));
      chk({tag, ".hold_idle"}, {md_busy, md_done, md_stall}, 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          dones;

      reset = 1'b1; md_start = 1'b0; md_flush = 1'b0;
      md_func3 = 3'd0; md_op1 = 32'h0; md_op2 = 32'h0; md_rd = 5'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset.outputs", {md_stall, md_busy, md_done, md_wr_reg, md_wr_regindex, md_result}, 64'(0));
      reset = 1'b0;

      run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
      idle_hold("mul_neg", 32'hFFFF_FFEB);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
      run_op("divu", 3'd5, 32'd100, 32'd7, 5'd7);
      run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8);
      run_op("divu_by0", 3'd5, 32'h1234, 32'd0, 5'd9);
      run_op("rem_by0", 3'd6, 32'h1234, 32'd0, 5'd10);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      idle_hold("rem_ovf", 32'h0);

      // Flush at CALC counter 10 (cycle 12 after start).
      run_op("pre_flush", 3'd5, 32'd50, 32'd5, 5'd1);
      @(negedge clk);
      md_start = 1'b1; md_func3 = 3'd4; md_op1 = 32'd1000; md_op2 = 32'd3; md_rd = 5'd13;
      repeat (12) @(negedge clk);
      md_flush = 1'b1; md_start = 1'b0;
      @(negedge clk);
      md_flush = 1'b0;
      #1;
      chk("flush.idle", {md_busy, md_stall, md_done}, 64'(0));
      chk("flush.result_kept", 64'(md_result), 64'd10);
      run_op("after_flush_mul", 3'd0, 32'd3, 32'd4, 5'd14);

      // Flush in the done cycle suppresses the writeback.
      @(negedge clk);
      md_start = 1'b1; md_func3 = 3'd5; md_op1 = 32'h55; md_op2 = 32'd0; md_rd = 5'd15;
      repeat (2) @(negedge clk);
      md_flush = 1'b1;
      #1;
      chk("flush_done.done", {md_done, md_wr_reg}, 64'(0));
      chk("flush_done.busy", 64'(md_busy), 64'd1);
      @(negedge clk);
      md_flush = 1'b0; md_start = 1'b0;
      #1;
      chk("flush_done.idle", 64'(md_busy), 64'd0);

      // Flush together with start in IDLE is not accepted.
      @(negedge clk);
      md_start = 1'b1; md_flush = 1'b1; md_func3 = 3'd0;
      #1;
      chk("flush_start.stall", 64'(md_stall), 64'd0);
      @(negedge clk);
      md_start = 1'b0; md_flush = 1'b0;
      #1;
      chk("flush_start.busy", 64'(md_busy), 64'd0);

      // Reset in the middle of CALC clears everything, and no done follows.
      @(negedge clk);
      md_start = 1'b1; md_func3 = 3'd0; md_op1 = 32'd9; md_op2 = 32'd9; md_rd = 5'd9;
      repeat (10) @(negedge clk);
      reset = 1'b1; md_start = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_reset.outputs", {md_stall, md_busy, md_done, md_wr_reg, md_wr_regindex, md_result}, 64'(0));
      reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (md_done) dones++;
      end
      chk("mid_reset.no_done", 64'(dones), 64'd0);

      run_op("mul_rd0", 3'd0, 32'd5, 32'd5, 5'd0);
      idle_hold("mul_rd0", 32'd25);

      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom_range(0, 31));
         run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, rd);
         if ($urandom_range(0, 1) == 1) idle_hold($sformatf("rnd%0d", i), ref_res(f, a, b));
      end
      idle_hold("final", ref_res(f, a, b));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
- Iterative multiply/divide sequencer for the RV32M ops that decode flags with de2ex_MD_OP (OPCODE_OP, func7==1).
- Accepts operands from the decode/execute boundary and time-shares one 33-bit add/sub and shift datapath over 32 iterations.
- Holds the pipeline with md_stall until the result is ready.
- Returns the result with the destination register index for writeback.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 5, iteration counter width (XLEN-1 must fit)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- md_start  input  1  valid M-extension op presented (de2ex_MD_OP & de2ex_inst_valid)
- md_func3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_op1  input  32  rs1 value (multiplicand/dividend)
- md_op2  input  32  rs2 value (multiplier/divisor)
- md_rd  input  5  destination register index
- md_flush  input  1  kill in-flight op (branch mispredict/exception)
- md_stall  output  1  hold decode/execute pipeline registers
- md_busy  output  1  state not IDLE
- md_done  output  1  one-cycle result-valid pulse
- md_result  output  32  result; valid when md_done
- md_wr_reg  output  1  writeback enable = md_done & (md_wr_regindex!=0)
- md_wr_regindex  output  5  latched md_rd

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): state=IDLE, counter=0, md_done=0, md_result=0, md_wr_regindex=0, md_wr_reg=0, md_busy=0. No done pulse is produced for an aborted op.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - md_start & !md_flush -> PREP.
  - Latch func3, rd, op1, op2.
- PREP (1 cycle):
  - Compute magnitudes per signedness: MULH both signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed; MUL treated unsigned.
  - Record sign flags.
  - Detect specials:
    - Divide by zero: op2==0 on func3 4-7.
    - Signed overflow: DIV/REM with op1==0x80000000 and op2==0xFFFFFFFF.
  - Special -> DONE directly with the fixed result. Otherwise -> CALC with counter=0.
- CALC (exactly 32 cycles, counter 0..31):
  - Multiply: radix-2 shift-add into 64-bit product {hi,lo}.
  - Divide: restoring; shift {rem,quot} left, trial-subtract divisor with the 33-bit adder, set quotient bit if non-negative.
  - counter==31 -> FIX.
- FIX (1 cycle):
  - Multiply: negate the 64-bit product if the operand signs differ (signed variants only).
  - DIV: negate the quotient if s1^s2.
  - REM: negate the remainder if s1.
  - Select lo (MUL), hi (MULH/MULHSU/MULHU), quotient (DIV/DIVU), or remainder (REM/REMU) into md_result.
  - -> DONE.
- DONE (1 cycle): md_done=1, md_result stable. -> IDLE. md_start is ignored in DONE because the same instruction is still presented.
- Special results:
  - Div-by-zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = op1.
  - Overflow: DIV = 0x80000000; REM = 0.
- Latency, with the start edge as cycle 0:
  - Normal op: md_done in cycle 35.
  - Special op: md_done in cycle 2.
- md_stall (combinational) = (IDLE & md_start & !md_flush) | PREP | CALC | FIX. It is low in DONE so the pipeline advances at the end of the done cycle.
- md_busy = state!=IDLE.
- md_flush:
  - In any state except IDLE: next state IDLE, no md_done; md_result keeps its previous value.
  - Flush in DONE suppresses the writeback: md_done and md_wr_reg are gated by !md_flush.
  - Flush together with start in IDLE: op not accepted.
- md_start in PREP/CALC/FIX is ignored (the pipeline is stalled).
- md_result holds its last value outside the done cycle.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE.

Test Plan:
- Reset, then MUL op1=7, op2=0xFFFFFFFD (-3), rd=5 -> md_stall high cycles 0-34; md_done only in cycle 35; md_result=0xFFFFFFEB; md_wr_reg=1; md_wr_regindex=5.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each at cycle 35.
- DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 2. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 2. REM same -> 0.
- DIV started, md_flush at CALC counter 10 -> IDLE next cycle, md_stall low, no md_done. New MUL 3x4 issued next -> 12 at cycle 35 after its start.
- reset asserted during CALC -> all outputs 0 next cycle. rd=0 MUL 5x5 -> md_done=1, md_wr_reg=0, md_result=25.
